ultra_range_rx: RTL and testbench

- Serial front end for the ultrasonic ranging sensor; sits upstream of the PicoBlaze controller.
- Receives the sensor's 8N1 ASCII stream on rxd and parses "R ddd CR" frames (0x52, three ASCII digits, 0x0D) into a binary range value.
- Emits a one-cycle valid strobe per good frame and a near-obstacle flag.
- Forwards every received byte with a strobe, so the controller can still see the raw stream.

---
 rtl/ultra_range_rx_if.sv | 25 ++
 rtl/ultra_range_rx.sv | 186 ++++++++++++++++++
 tb/tb_ultra_range_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ultra_range_rx_if.sv
// Serial input and decoded outputs of the ultrasonic ranging receiver.
// The receiver drives the master side. The controller or bench uses the slave side.
interface ultra_range_rx_if;
    logic       rxd;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_ferr;
    logic       rx_busy;
    logic [9:0] range;
    logic       range_valid;
    logic       frame_err;
    logic       near;

    modport master (
        input  rxd,
        output rx_byte, rx_strobe, rx_ferr, rx_busy,
        output range, range_valid, frame_err, near
    );

    modport slave (
        output rxd,
        input  rx_byte, rx_strobe, rx_ferr, rx_busy,
        input  range, range_valid, frame_err, near
    );
endinterface

// File: rtl/ultra_range_rx.sv
// 8N1 UART receiver and "R ddd CR" frame parser for the ultrasonic ranging sensor.
// It produces a binary range, a near-obstacle flag and a raw byte stream for the controller.
module ultra_range_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int NEAR_THRESH  = 24
) (
    input  logic              clk,
    input  logic              reset,
    ultra_range_rx_if.master  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [9:0]    NEAR_T   = 10'(NEAR_THRESH);

    typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT} u_state_t;
    typedef enum logic [2:0] {P_IDLE, P_D0, P_D1, P_D2, P_CR} p_state_t;

    logic          rxd_meta, rxs;
    u_state_t      u_state, u_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shreg, sh_nxt;
    logic [7:0]    rx_byte_q, byte_nxt;
    logic          strobe_q, strobe_nxt;
    logic          uferr_q, uferr_nxt;

    p_state_t      p_state, p_nxt;
    logic [9:0]    acc, acc_nxt;
    logic [9:0]    range_q, range_nxt;
    logic          near_q, near_nxt;
    logic          valid_q, valid_nxt;
    logic          ferr_q, ferr_nxt;

    // rxd is asynchronous, so it passes through a two-flop synchronizer that idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= bus.rxd;
            rxs      <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_state   <= U_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte_q <= '0;
            strobe_q  <= 1'b0;
            uferr_q   <= 1'b0;
        end else begin
            u_state   <= u_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            shreg     <= sh_nxt;
            rx_byte_q <= byte_nxt;
            strobe_q  <= strobe_nxt;
            uferr_q   <= uferr_nxt;
        end
    end

    // The counter starts at the half-bit point, so every later expiry lands at mid-bit.
    always_comb begin
        u_nxt      = u_state;
        cnt_nxt    = cnt;
        bit_nxt    = bit_idx;
        sh_nxt     = shreg;
        byte_nxt   = rx_byte_q;
        strobe_nxt = 1'b0;
        uferr_nxt  = 1'b0;
        case (u_state)
            U_IDLE: if (!rxs) begin
                cnt_nxt = HALF_CNT;
                u_nxt   = U_START;
            end
            U_START: if (cnt == '0) begin
                if (!rxs) begin
                    u_nxt   = U_DATA;
                    cnt_nxt = BIT_CNT;
                    bit_nxt = '0;
                end else begin
                    u_nxt = U_IDLE;
                end
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
            U_DATA: if (cnt == '0) begin
                sh_nxt  = {rxs, shreg[7:1]};
                cnt_nxt = BIT_CNT;
                bit_nxt = bit_idx + 3'd1;
                if (bit_idx == 3'd7) u_nxt = U_STOP;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
            U_STOP: if (cnt == '0) begin
                if (rxs) begin
                    byte_nxt   = shreg;
                    strobe_nxt = 1'b1;
                    u_nxt      = U_IDLE;
                end else begin
                    uferr_nxt = 1'b1;
                    u_nxt     = U_WAIT;
                end
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
            U_WAIT: if (rxs) u_nxt = U_IDLE;
            default: u_nxt = U_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state <= P_IDLE;
            acc     <= '0;
            range_q <= '0;
            near_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            p_state <= p_nxt;
            acc     <= acc_nxt;
            range_q <= range_nxt;
            near_q  <= near_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
        end
    end

    // An 'R' always starts a new frame. It is an error only if it interrupts a partial frame.
    always_comb begin
        p_nxt     = p_state;
        acc_nxt   = acc;
        range_nxt = range_q;
        near_nxt  = near_q;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        if (strobe_q) begin
            if (rx_byte_q == 8'h52) begin
                ferr_nxt = (p_state != P_IDLE);
                acc_nxt  = '0;
                p_nxt    = P_D0;
            end else begin
                case (p_state)
                    P_D0, P_D1, P_D2: begin
                        if (rx_byte_q >= 8'h30 && rx_byte_q <= 8'h39) begin
                            acc_nxt = (acc << 3) + (acc << 1) + {6'd0, rx_byte_q[3:0]};
                            p_nxt   = (p_state == P_D0) ? P_D1 :
                                      (p_state == P_D1) ? P_D2 : P_CR;
                        end else begin
                            ferr_nxt = 1'b1;
                            p_nxt    = P_IDLE;
                        end
                    end
                    P_CR: begin
                        if (rx_byte_q == 8'h0D) begin
                            range_nxt = acc;
                            near_nxt  = (acc < NEAR_T);
                            valid_nxt = 1'b1;
                        end else begin
                            ferr_nxt = 1'b1;
                        end
                        p_nxt = P_IDLE;
                    end
                    default: p_nxt = P_IDLE;
                endcase
            end
        end else if (uferr_q && p_state != P_IDLE) begin
            ferr_nxt = 1'b1;
            p_nxt    = P_IDLE;
        end
    end

    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_strobe   = strobe_q;
    assign bus.rx_ferr     = uferr_q;
    assign bus.rx_busy     = (u_state == U_DATA) || (u_state == U_STOP);
    assign bus.range       = range_q;
    assign bus.range_valid = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.near        = near_q;
endmodule

// File: tb/tb_ultra_range_rx.sv
// Directed bench for ultra_range_rx: frame vectors from a table, plus sequences for
// glitch, stop-bit error and mid-frame reset.
module tb_ultra_range_rx;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ultra_range_rx_if u_if ();

    ultra_range_rx #(.CLKS_PER_BIT(CPB), .NEAR_THRESH(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1);
    end

    // Event monitor: cumulative counts sampled on the falling edge.
    int         cyc = 0;
    int         n_strobe = 0, n_valid = 0, n_ferr = 0, n_rxferr = 0, n_busy = 0;
    int         last_strobe_cyc = 0, valid_lat = 0;
    logic [7:0] last_strobe_byte = 8'h00, ferr_byte = 8'h00, valid_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.rx_strobe) begin
            n_strobe         <= n_strobe + 1;
            last_strobe_cyc  <= cyc;
            last_strobe_byte <= u_if.rx_byte;
        end
        if (u_if.range_valid) begin
            n_valid    <= n_valid + 1;
            valid_lat  <= cyc - last_strobe_cyc;
            valid_byte <= last_strobe_byte;
        end
        if (u_if.frame_err) begin
            n_ferr    <= n_ferr + 1;
            ferr_byte <= last_strobe_byte;
        end
        if (u_if.rx_ferr) n_rxferr <= n_rxferr + 1;
        if (u_if.rx_busy) n_busy   <= n_busy + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        u_if.rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rxd = d[i];
            repeat (CPB) @(posedge clk);
        end
        u_if.rxd = stop;
        repeat (CPB) @(posedge clk);
        u_if.rxd = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    typedef struct {
        logic [63:0] b;
        int          n;
        int          exp_strobe;
        int          exp_valid;
        int          exp_ferr;
        int          exp_range;
        int          exp_near;
        logic [7:0]  exp_ferr_byte;
    } vec_t;

    function automatic vec_t mk(input logic [63:0] b, input int n, input int s, input int v,
                                input int f, input int r, input int nr, input logic [7:0] fb);
        vec_t t;
        t.b = b; t.n = n; t.exp_strobe = s; t.exp_valid = v; t.exp_ferr = f;
        t.exp_range = r; t.exp_near = nr; t.exp_ferr_byte = fb;
        return t;
    endfunction

    task automatic send_frame(input logic [63:0] b, input int n);
        for (int k = 0; k < n; k++) send_byte(b[8*(n-1-k) +: 8], 1'b1);
        repeat (10) @(posedge clk);
    endtask

    vec_t vecs[4];
    int   s_strobe, s_valid, s_ferr, s_rxferr, s_busy;

    task automatic snap();
        @(negedge clk);
        s_strobe = n_strobe; s_valid = n_valid; s_ferr = n_ferr;
        s_rxferr = n_rxferr; s_busy = n_busy;
    endtask

    initial begin
        vecs[0] = mk({24'd0, "R012",  8'h0D}, 5, 5, 1, 0, 12,  1, 8'h00);
        vecs[1] = mk({24'd0, "R345",  8'h0D}, 5, 5, 1, 0, 345, 0, 8'h00);
        vecs[2] = mk({8'd0,  "R3R456", 8'h0D}, 7, 7, 1, 1, 456, 0, 8'h52);
        vecs[3] = mk({24'd0, "R1A3",  8'h0D}, 5, 5, 0, 1, 456, 0, 8'h41);

        u_if.rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_byte",     int'(u_if.rx_byte),     0);
        chk("reset_rx_strobe",   int'(u_if.rx_strobe),   0);
        chk("reset_rx_busy",     int'(u_if.rx_busy),     0);
        chk("reset_range",       int'(u_if.range),       0);
        chk("reset_range_valid", int'(u_if.range_valid), 0);
        chk("reset_near",        int'(u_if.near),        0);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        for (int v = 0; v < 4; v++) begin
            snap();
            send_frame(vecs[v].b, vecs[v].n);
            @(negedge clk);
            chk($sformatf("v%0d_strobes", v),   n_strobe - s_strobe, vecs[v].exp_strobe);
            chk($sformatf("v%0d_valids", v),    n_valid - s_valid,   vecs[v].exp_valid);
            chk($sformatf("v%0d_frame_err", v), n_ferr - s_ferr,     vecs[v].exp_ferr);
            chk($sformatf("v%0d_range", v),     int'(u_if.range),    vecs[v].exp_range);
            chk($sformatf("v%0d_near", v),      int'(u_if.near),     vecs[v].exp_near);
            chk($sformatf("v%0d_last_byte", v), int'(u_if.rx_byte),  8'h0D);
            chk($sformatf("v%0d_busy_idle", v), int'(u_if.rx_busy),  0);
            if (vecs[v].exp_valid > 0) begin
                chk($sformatf("v%0d_valid_latency", v), valid_lat, 1);
                chk($sformatf("v%0d_valid_after_cr", v), int'(valid_byte), 8'h0D);
            end
            if (vecs[v].exp_ferr > 0)
                chk($sformatf("v%0d_ferr_byte", v), int'(ferr_byte), int'(vecs[v].exp_ferr_byte));
        end

        // A short low pulse on rxd must be rejected as a glitch.
        snap();
        u_if.rxd = 1'b0;
        repeat (4) @(posedge clk);
        u_if.rxd = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("glitch_strobes", n_strobe - s_strobe, 0);
        chk("glitch_busy",    n_busy - s_busy,     0);
        chk("glitch_rxferr",  n_rxferr - s_rxferr, 0);

        // A bad stop bit with the parser idle gives rx_ferr but no frame_err.
        snap();
        send_byte(8'h52, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stoperr_rxferr",    n_rxferr - s_rxferr, 1);
        chk("stoperr_strobes",   n_strobe - s_strobe, 0);
        chk("stoperr_frame_err", n_ferr - s_ferr,     0);
        snap();
        send_frame({24'd0, "R007", 8'h0D}, 5);
        @(negedge clk);
        chk("after_stoperr_valid", n_valid - s_valid, 1);
        chk("after_stoperr_range", int'(u_if.range),  7);
        chk("after_stoperr_near",  int'(u_if.near),   1);

        // A bad stop bit in the middle of a frame aborts the frame.
        snap();
        send_byte(8'h52, 1'b1);
        send_byte(8'h31, 1'b0);
        send_frame({56'd0, 8'h0D}, 1);
        @(negedge clk);
        chk("midframe_rxferr_frame_err", n_ferr - s_ferr,   1);
        chk("midframe_rxferr_valid",     n_valid - s_valid, 0);
        chk("midframe_rxferr_range",     int'(u_if.range),  7);

        // A reset during the second digit discards the frame and clears all outputs.
        send_byte(8'h52, 1'b1);
        send_byte(8'h32, 1'b1);
        u_if.rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            u_if.rxd = 1'b0;
            repeat (CPB) @(posedge clk);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_range",     int'(u_if.range),     0);
        chk("midreset_near",      int'(u_if.near),      0);
        chk("midreset_rx_byte",   int'(u_if.rx_byte),   0);
        chk("midreset_rx_busy",   int'(u_if.rx_busy),   0);
        chk("midreset_frame_err", int'(u_if.frame_err), 0);
        chk("midreset_rx_ferr",   int'(u_if.rx_ferr),   0);
        u_if.rxd = 1'b1;
        repeat (4) @(posedge clk);
        reset = 1'b1;
        repeat (CPB) @(posedge clk);
        snap();
        send_frame({24'd0, "R200", 8'h0D}, 5);
        @(negedge clk);
        chk("postreset_valid",     n_valid - s_valid, 1);
        chk("postreset_frame_err", n_ferr - s_ferr,   0);
        chk("postreset_range",     int'(u_if.range),  200);
        chk("postreset_near",      int'(u_if.near),   0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
